prog_clock_divider: RTL and testbench

Runtime-programmable integer clock divider, the parametrised successor to the fixed power-of-two divider. Divides `clk` by any N in [2, 2^WIDTH−1] with 50 % duty for both even and odd N. Divisor updates through a valid/ready handshake and take effect only at a period boundary, so `clk_out` never glitches. An enable starts and stops the output cleanly, and a `tick` pulse in the `clk` domain marks each output rising edge for synchronous consumers.

---
 rtl/prog_clock_divider_pkg.sv | 13 +
 rtl/clk_duty_fix.sv | 25 ++
 rtl/prog_clock_divider.sv | 132 +++++++++++++
 tb/tb_prog_clock_divider.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_clock_divider_pkg.sv
// Shared types and constants for the programmable clock divider.
// Contents: FSM state enum and the smallest legal divisor.
package prog_clock_divider_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } div_state_e;

    localparam int MIN_DIV = 2;

endpackage

// File: rtl/clk_duty_fix.sv
// Negedge half-cycle stretcher and odd/even output select.
// Ports: clk, rst, p_q (posedge phase flop), odd_sel, clk_out.
module clk_duty_fix (
    input  logic clk,
    input  logic rst,
    input  logic p_q,
    input  logic odd_sel,
    output logic clk_out
);

    logic n_q;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            n_q <= 1'b0;
        end else begin
            n_q <= p_q;
        end
    end

    // For odd N, ANDing with the half-cycle-late copy delays the rise
    // by half a clk cycle, trimming ceil(N/2) high cycles to exactly N/2.
    assign clk_out = odd_sel ? (p_q & n_q) : p_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Runtime-programmable 50% duty integer clock divider.
// Ports: clk, rst, en, div_in/div_valid/div_ready handshake, div_err,
//        clk_out, tick (clk-domain marker of clk_out rise), cur_div.
module prog_clock_divider
    import prog_clock_divider_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] div_in,
    input  logic             div_valid,
    output logic             div_ready,
    output logic             div_err,
    output logic             clk_out,
    output logic             tick,
    output logic [WIDTH-1:0] cur_div
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    div_state_e       state;
    logic [WIDTH-1:0] phase;
    logic [WIDTH-1:0] phase_inc;
    logic [WIDTH-1:0] div_act;
    logic [WIDTH-1:0] pend_div;
    logic [WIDTH-1:0] half;
    logic             pend_valid;
    logic             odd_sel;
    logic             p_q;
    logic             running;
    logic             wrap;
    logic             act;
    logic             accept;
    logic             hi;

    // The phase counter runs one cycle ahead of what p_q/tick display,
    // so div_act governs the counter a cycle before cur_div shows it.
    assign phase_inc = phase + WIDTH'(1);
    assign running   = (state != IDLE);
    assign wrap      = running && (phase_inc == div_act);
    assign act       = pend_valid && ((state == IDLE) || wrap);
    assign accept    = div_valid && div_ready;
    assign half      = div_act >> 1;
    // High for phases 0 .. ceil(N/2)-1.
    assign hi        = (phase < half) || (div_act[0] && (phase == half));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            phase      <= '0;
            div_act    <= DEF_DIV;
            pend_div   <= DEF_DIV;
            pend_valid <= 1'b0;
            div_ready  <= 1'b1;
            div_err    <= 1'b0;
            cur_div    <= DEF_DIV;
            odd_sel    <= DEF_DIV[0];
            p_q        <= 1'b0;
            tick       <= 1'b0;
        end else begin
            div_err <= 1'b0;

            if (accept) begin
                if (div_in < WIDTH'(MIN_DIV)) begin
                    div_err <= 1'b1;
                end else begin
                    pend_div   <= div_in;
                    pend_valid <= 1'b1;
                    div_ready  <= 1'b0;
                end
            end

            if (act) begin
                div_act    <= pend_div;
                pend_valid <= 1'b0;
                div_ready  <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    phase <= '0;
                    p_q   <= 1'b0;
                    tick  <= 1'b0;
                    if (en) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    p_q   <= hi;
                    tick  <= (phase == '0);
                    phase <= wrap ? '0 : phase_inc;
                    if (!en) begin
                        state <= wrap ? IDLE : DRAIN;
                    end
                end
                DRAIN: begin
                    p_q   <= hi;
                    tick  <= (phase == '0);
                    phase <= wrap ? '0 : phase_inc;
                    if (wrap) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            // cur_div and the duty select follow the displayed period:
            // they switch with tick while running, immediately when idle.
            if (act && (state == IDLE)) begin
                cur_div <= pend_div;
                odd_sel <= pend_div[0];
            end else if ((state == IDLE) || (phase == '0)) begin
                cur_div <= div_act;
                odd_sel <= div_act[0];
            end
        end
    end

    clk_duty_fix u_duty (
        .clk     (clk),
        .rst     (rst),
        .p_q     (p_q),
        .odd_sel (odd_sel),
        .clk_out (clk_out)
    );

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider.
// Drives at posedge+1, samples clk_out at half-cycle steps.
module tb_prog_clock_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] div_in;
    logic       div_valid;
    logic       div_ready;
    logic       div_err;
    logic       clk_out;
    logic       tick;
    logic [7:0] cur_div;

    int total = 0;
    int bad   = 0;

    prog_clock_divider #(
        .WIDTH       (8),
        .DEFAULT_DIV (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .div_in    (div_in),
        .div_valid (div_valid),
        .div_ready (div_ready),
        .div_err   (div_err),
        .clk_out   (clk_out),
        .tick      (tick),
        .cur_div   (cur_div)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, got, exp);
        end
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic find_rise();
        logic prev;
        bit   ok;
        ok   = 1'b0;
        prev = clk_out;
        for (int i = 0; i < 1200; i++) begin
            #5;
            if (clk_out && !prev) begin
                ok = 1'b1;
                break;
            end
            prev = clk_out;
        end
        if (!ok) chk("rise_timeout", 0, 1);
    endtask

    // Called right at a rising sample; counts half cycles to next rise.
    task automatic meas(input string tag, input int per, input int hi);
        int   p;
        int   h;
        logic prev;
        bit   ok;
        p    = 1;
        h    = 1;
        prev = 1'b1;
        ok   = 1'b0;
        for (int i = 0; i < 1200; i++) begin
            #5;
            if (clk_out && !prev) begin
                ok = 1'b1;
                break;
            end
            h    += int'(clk_out);
            p++;
            prev = clk_out;
        end
        chk({tag, "_per"}, ok ? p : 0, per);
        chk({tag, "_hi"}, h, hi);
    endtask

    task automatic wait_div(input int d, input int lim);
        int i;
        i = 0;
        while (cur_div !== 8'(d) && i < lim) begin
            to_pos();
            i++;
        end
        chk("wait_div", int'(cur_div), d);
    endtask

    task automatic load(input int d);
        to_pos();
        div_in    = 8'(d);
        div_valid = 1'b1;
        to_pos();
        div_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        div_in    = '0;
        div_valid = 1'b0;

        // reset state
        #6;
        chk("rst_clk", int'(clk_out), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_err", int'(div_err), 0);
        chk("rst_rdy", int'(div_ready), 1);
        chk("rst_div", int'(cur_div), 4);
        #10;
        rst = 1'b0;

        // start with N=4: en sampled next posedge, rise one later
        en = 1'b1;
        to_pos();
        chk("start_lat", int'(clk_out), 0);
        for (int j = 0; j < 8; j++) begin
            to_pos();
            chk("n4_clk", int'(clk_out), ((j % 4) < 2) ? 1 : 0);
            chk("n4_tick", int'(tick), ((j % 4) == 0) ? 1 : 0);
        end

        // load 5 at phase 3; old period of 4 completes first
        div_in    = 8'd5;
        div_valid = 1'b1;
        to_pos();
        div_valid = 1'b0;
        chk("n5_rdy0", int'(div_ready), 0);
        chk("n5_div0", int'(cur_div), 4);
        chk("n5_tick0", int'(tick), 1);
        to_pos();
        chk("n5_rdy1", int'(div_ready), 0);
        chk("n5_clk1", int'(clk_out), 1);
        to_pos();
        chk("n5_rdy2", int'(div_ready), 0);
        chk("n5_clk2", int'(clk_out), 0);
        to_pos();
        chk("n5_rdy3", int'(div_ready), 1);
        chk("n5_div3", int'(cur_div), 4);
        chk("n5_tick3", int'(tick), 0);
        to_pos();
        chk("n5_tick4", int'(tick), 1);
        chk("n5_div4", int'(cur_div), 5);
        chk("n5_late", int'(clk_out), 0);
        #5;
        chk("n5_rise", int'(clk_out), 1);
        meas("n5", 10, 5);

        // N=2 then N=255
        load(2);
        chk("n2_rdy", int'(div_ready), 0);
        wait_div(2, 20);
        find_rise();
        meas("n2", 4, 2);
        load(255);
        wait_div(255, 20);
        find_rise();
        meas("n255", 510, 255);

        // rejected requests
        to_pos();
        div_in    = 8'd1;
        div_valid = 1'b1;
        to_pos();
        div_valid = 1'b0;
        chk("rej1_err", int'(div_err), 1);
        chk("rej1_rdy", int'(div_ready), 1);
        to_pos();
        chk("rej1_pulse", int'(div_err), 0);
        div_in    = 8'd0;
        div_valid = 1'b1;
        to_pos();
        div_valid = 1'b0;
        chk("rej0_err", int'(div_err), 1);
        chk("rej0_rdy", int'(div_ready), 1);
        to_pos();
        chk("rej0_pulse", int'(div_err), 0);
        chk("rej_div", int'(cur_div), 255);
        find_rise();
        meas("rej", 510, 255);

        // N=6, drop en at displayed phase 1
        load(6);
        wait_div(6, 300);
        to_pos();
        en = 1'b0;
        to_pos();
        chk("drain_p2", int'(clk_out), 1);
        to_pos();
        chk("drain_p3", int'(clk_out), 0);
        to_pos();
        to_pos();
        for (int j = 0; j < 4; j++) begin
            to_pos();
            chk("idle_clk", int'(clk_out), 0);
            chk("idle_tick", int'(tick), 0);
        end

        // restart: full first high phase of 3
        en = 1'b1;
        to_pos();
        chk("rs_lat", int'(clk_out), 0);
        for (int j = 0; j < 4; j++) begin
            to_pos();
            chk("rs_clk", int'(clk_out), (j < 3) ? 1 : 0);
            chk("rs_tick", int'(tick), (j == 0) ? 1 : 0);
        end

        // reset mid high phase with a divisor pending
        for (int j = 0; j < 20 && !tick; j++) to_pos();
        chk("pre_tick", int'(tick), 1);
        div_in    = 8'd9;
        div_valid = 1'b1;
        to_pos();
        div_valid = 1'b0;
        chk("pre_rdy", int'(div_ready), 0);
        chk("pre_clk", int'(clk_out), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_clk", int'(clk_out), 0);
        chk("ar_tick", int'(tick), 0);
        chk("ar_rdy", int'(div_ready), 1);
        chk("ar_err", int'(div_err), 0);
        chk("ar_div", int'(cur_div), 4);
        to_pos();
        to_pos();
        rst = 1'b0;
        find_rise();
        meas("post_rst", 8, 4);
        to_pos();
        to_pos();
        to_pos();
        chk("lost_pend", int'(cur_div), 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
